qqspi_mem_target: RTL and testbench

//  SPI/QPI memory responder: the device-side counterpart of the qqspi controller. Decodes
//  0x02/0x03 (1-bit) and 0x38/0xEB (quad) PSRAM-style commands, each with a 24-bit address.

---
 rtl/qqspi_mem_target.sv | 220 ++++++++++++++++++++++
 tb/tb_qqspi_mem_target.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qqspi_mem_target.sv
// qqspi_mem_target: SPI/QPI PSRAM-style memory responder with backdoor port.
//   Decodes 0x02/0x03 (1-bit write/read) and 0x38/0xEB (quad write/read).
//   Each command carries a 24-bit address, and the bus runs in SPI mode 3.
//   All bus inputs are oversampled by clk through SYNC_STAGES flops.
// Ports:
//   clk, resetn            system clock, synchronous active-low reset
//   cs_n, sclk, sio_i[3:0] raw bus inputs (sio_i[0]=mosi, sio_i[1]=miso line)
//   sio_o[3:0], sio_oe     registered bus drive and per-line output enables
//   bd_we/bd_addr/bd_wdata backdoor write, accepted only while cs_n is high
//   bd_rdata               registered mem[bd_addr], 1-cycle latency
//   busy                   registered, high while the FSM is not in IDLE
module qqspi_mem_target #(
  parameter int MEM_BYTES   = 4096,
  parameter int SYNC_STAGES = 2,
  parameter int DUMMY_CYC   = 6,
  localparam int AW         = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cs_n,
  input  logic          sclk,
  input  logic [3:0]    sio_i,
  output logic [3:0]    sio_o,
  output logic [3:0]    sio_oe,
  input  logic          bd_we,
  input  logic [AW-1:0] bd_addr,
  input  logic [7:0]    bd_wdata,
  output logic [7:0]    bd_rdata,
  output logic          busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR1  = 3'd2,
    ST_ADDRQ  = 3'd3,
    ST_DUMMY  = 3'd4,
    ST_WDATA  = 3'd5,
    ST_RDATA  = 3'd6,
    ST_IGNORE = 3'd7
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0]      cs_sync_q, sclk_sync_q;
  logic [SYNC_STAGES-1:0][3:0] sio_sync_q;
  logic                        cs_prev_q, sclk_prev_q;
  logic                        cs_s, sclk_s, cs_fall, sclk_rise, sclk_fall;
  logic [3:0]                  sio_s;

  logic [4:0]    cnt_q;
  logic [7:0]    cmd_q, cmd_next, wbyte_q, wbyte_next, rd_byte;
  logic [AW-1:0] addr_q;
  logic          quad_w, quad_r, bus_we;
  logic [4:0]    wlast, rlast;
  logic [7:0]    mem_q [MEM_BYTES];

  logic [3:0] sio_o_q, sio_o_d, sio_oe_q, sio_oe_d;
  logic       busy_q, busy_d;
  logic [7:0] bd_rdata_q;

  // Input synchronisers and edge-history flops; left unreset so that a reset
  // released while cs_n is already low cannot fabricate a cs_n fall.
  always_ff @(posedge clk) begin
    cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    sio_sync_q  <= {sio_sync_q[SYNC_STAGES-2:0], sio_i};
    cs_prev_q   <= cs_s;
    sclk_prev_q <= sclk_s;
  end

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sio_s     = sio_sync_q[SYNC_STAGES-1];
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  assign cmd_next   = {cmd_q[6:0], sio_s[0]};
  assign quad_w     = (cmd_q == 8'h38);
  assign quad_r     = (cmd_q == 8'hEB);
  assign wlast      = quad_w ? 5'd1 : 5'd7;
  assign rlast      = quad_r ? 5'd1 : 5'd7;
  assign wbyte_next = quad_w ? {wbyte_q[3:0], sio_s} : {wbyte_q[6:0], sio_s[0]};
  assign rd_byte    = mem_q[addr_q];
  // state_d stays WDATA only while cs_n is low, so an aborted byte never lands.
  assign bus_we     = (state_q == ST_WDATA) && (state_d == ST_WDATA) &&
                      sclk_rise && (cnt_q == wlast);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic; a synchronised cs_n high overrides everything.
  always_comb begin
    state_d = state_q;
    if (cs_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (cs_fall) state_d = ST_CMD;
        ST_CMD: begin
          if (sclk_rise && cnt_q == 5'd7) begin
            if (cmd_next == 8'h02 || cmd_next == 8'h03)      state_d = ST_ADDR1;
            else if (cmd_next == 8'h38 || cmd_next == 8'hEB) state_d = ST_ADDRQ;
            else                                             state_d = ST_IGNORE;
          end
        end
        ST_ADDR1: if (sclk_rise && cnt_q == 5'd23)
                    state_d = (cmd_q == 8'h02) ? ST_WDATA : ST_RDATA;
        ST_ADDRQ: if (sclk_rise && cnt_q == 5'd5)
                    state_d = (cmd_q == 8'h38) ? ST_WDATA : ST_DUMMY;
        ST_DUMMY: if (sclk_rise && cnt_q == 5'(DUMMY_CYC - 1)) state_d = ST_RDATA;
        default:  state_d = state_q;
      endcase
    end
  end

  // FSM outputs: read data is launched on synchronised sclk falls only.
  always_comb begin
    sio_o_d  = sio_o_q;
    sio_oe_d = sio_oe_q;
    busy_d   = (state_d != ST_IDLE);
    if (state_d != ST_RDATA) begin
      sio_o_d  = 4'b0000;
      sio_oe_d = 4'b0000;
    end else if (state_q == ST_RDATA && sclk_fall) begin
      if (quad_r) begin
        sio_o_d  = (cnt_q[0] == 1'b0) ? rd_byte[7:4] : rd_byte[3:0];
        sio_oe_d = 4'b1111;
      end else begin
        sio_o_d  = {2'b00, rd_byte[3'd7 - cnt_q[2:0]], 1'b0};
        sio_oe_d = 4'b0010;
      end
    end else begin
      sio_o_d  = sio_o_q;
      sio_oe_d = sio_oe_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sio_o_q  <= 4'b0000;
      sio_oe_q <= 4'b0000;
      busy_q   <= 1'b0;
    end else begin
      sio_o_q  <= sio_o_d;
      sio_oe_q <= sio_oe_d;
      busy_q   <= busy_d;
    end
  end

  // Shift/count datapath; the counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q   <= 5'd0;
      cmd_q   <= 8'h00;
      addr_q  <= '0;
      wbyte_q <= 8'h00;
    end else begin
      case (state_q)
        ST_CMD: if (sclk_rise) begin
          cmd_q <= cmd_next;
          cnt_q <= cnt_q + 5'd1;
        end
        // Only the low AW address bits survive the shift.
        ST_ADDR1: if (sclk_rise) begin
          addr_q <= {addr_q[AW-2:0], sio_s[0]};
          cnt_q  <= cnt_q + 5'd1;
        end
        ST_ADDRQ: if (sclk_rise) begin
          addr_q <= {addr_q[AW-5:0], sio_s};
          cnt_q  <= cnt_q + 5'd1;
        end
        ST_DUMMY: if (sclk_rise) cnt_q <= cnt_q + 5'd1;
        ST_WDATA: if (sclk_rise) begin
          wbyte_q <= wbyte_next;
          if (cnt_q == wlast) begin
            cnt_q  <= 5'd0;
            addr_q <= addr_q + AW'(1);
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        // Advance to the next byte once its last bit/nibble is on the bus.
        ST_RDATA: if (sclk_fall) begin
          if (cnt_q == rlast) begin
            cnt_q  <= 5'd0;
            addr_q <= addr_q + AW'(1);
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        default: ;
      endcase
      if (state_d != state_q) cnt_q <= 5'd0;
    end
  end

  // Byte RAM; bus writes take priority, backdoor only while cs_n is high.
  always_ff @(posedge clk) begin
    if (resetn && bus_we)  mem_q[addr_q]  <= wbyte_next;
    else if (bd_we && cs_s) mem_q[bd_addr] <= bd_wdata;
  end

  // Registered backdoor read port.
  always_ff @(posedge clk) begin
    if (!resetn) bd_rdata_q <= 8'h00;
    else         bd_rdata_q <= mem_q[bd_addr];
  end

  assign sio_o    = sio_o_q;
  assign sio_oe   = sio_oe_q;
  assign busy     = busy_q;
  assign bd_rdata = bd_rdata_q;

endmodule

// File: tb/tb_qqspi_mem_target.sv
// Bench for qqspi_mem_target: bus-master tasks drive SPI/QPI transactions,
// a byte-array reference model predicts RAM contents and read data.
module tb_qqspi_mem_target;
  localparam int MEM  = 4096;
  localparam int SS   = 2;
  localparam int DC   = 6;
  localparam int CLKP = 10;
  localparam int HALF = 60;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cs_n = 1'b1;
  logic        sclk = 1'b1;
  logic [3:0]  sio_i = 4'h0;
  logic [3:0]  sio_o, sio_oe;
  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = 12'h000;
  logic [7:0]  bd_wdata = 8'h00;
  logic [7:0]  bd_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int oe_viol;
  logic [7:0] ref_mem [0:MEM-1];
  logic [7:0] wbuf [0:7];
  logic [7:0] rbuf [0:7];
  logic [3:0] last_q;

  qqspi_mem_target #(.MEM_BYTES(MEM), .SYNC_STAGES(SS), .DUMMY_CYC(DC)) dut (
    .clk(clk), .resetn(resetn), .cs_n(cs_n), .sclk(sclk), .sio_i(sio_i),
    .sio_o(sio_o), .sio_oe(sio_oe), .bd_we(bd_we), .bd_addr(bd_addr),
    .bd_wdata(bd_wdata), .bd_rdata(bd_rdata), .busy(busy)
  );

  always #(CLKP/2) clk = ~clk;

  // One sclk cycle: drive on fall, sample DUT just before the rise.
  task automatic sbit(input logic [3:0] d, input logic [3:0] oe_exp);
    sclk = 1'b0; sio_i = d;
    #(HALF);
    last_q = sio_o;
    if (sio_oe !== oe_exp) oe_viol++;
    sclk = 1'b1;
    #(HALF);
  endtask

  task automatic xfer_start();
    @(negedge clk);
    cs_n = 1'b0;
    #(HALF);
  endtask

  task automatic xfer_stop();
    #(HALF);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
    for (int i = 7; i >= 0; i--) sbit({3'b000, cmd[i]}, 4'b0000);
    if (cmd == 8'h38 || cmd == 8'hEB)
      for (int n = 5; n >= 0; n--) sbit(addr[4*n +: 4], 4'b0000);
    else
      for (int i = 23; i >= 0; i--) sbit({3'b000, addr[i]}, 4'b0000);
  endtask

  task automatic bus_write(input logic [7:0] cmd, input logic [23:0] addr, input int n);
    logic [11:0] a;
    oe_viol = 0;
    xfer_start();
    send_hdr(cmd, addr);
    for (int b = 0; b < n; b++) begin
      if (cmd == 8'h38) begin
        sbit(wbuf[b][7:4], 4'b0000);
        sbit(wbuf[b][3:0], 4'b0000);
      end else begin
        for (int i = 7; i >= 0; i--) sbit({3'b000, wbuf[b][i]}, 4'b0000);
      end
      a = addr[11:0] + 12'(b);
      ref_mem[a] = wbuf[b];
    end
    xfer_stop();
  endtask

  task automatic bus_read(input logic [7:0] cmd, input logic [23:0] addr, input int n);
    oe_viol = 0;
    xfer_start();
    send_hdr(cmd, addr);
    if (cmd == 8'hEB) repeat (DC) sbit(4'h0, 4'b0000);
    for (int b = 0; b < n; b++) begin
      if (cmd == 8'hEB) begin
        sbit(4'h0, 4'b1111); rbuf[b][7:4] = last_q;
        sbit(4'h0, 4'b1111); rbuf[b][3:0] = last_q;
      end else begin
        for (int i = 7; i >= 0; i--) begin
          sbit(4'h0, 4'b0010);
          rbuf[b][i] = last_q[1];
        end
      end
    end
    xfer_stop();
  endtask

  task automatic bd_write(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_wdata = d;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic bd_read(input logic [11:0] a, output logic [7:0] d);
    @(negedge clk);
    bd_addr = a;
    @(posedge clk);
    #1;
    d = bd_rdata;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (sio_oe !== 4'b0000) begin errors++; $display("FAIL reset_oe got %b exp 0000", sio_oe); end
    checks++; if (sio_o !== 4'b0000) begin errors++; $display("FAIL reset_sio_o got %b exp 0000", sio_o); end
    checks++; if (bd_rdata !== 8'h00) begin errors++; $display("FAIL reset_bd_rdata got %h exp 00", bd_rdata); end
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_backdoor();
    logic [7:0] d;
    logic [11:0] a;
    for (int i = 0; i < MEM; i++) bd_write(12'(i), 8'($urandom));
    for (int i = 0; i < 8; i++) begin
      a = 12'($urandom);
      bd_read(a, d);
      checks++;
      if (d !== ref_mem[a]) begin errors++; $display("FAIL backdoor_rd addr %h got %h exp %h", a, d, ref_mem[a]); end
    end
  endtask

  task automatic check_ram(input logic [11:0] base, input int n, input string name);
    logic [7:0] d;
    logic [11:0] a;
    for (int b = 0; b < n; b++) begin
      a = base + 12'(b);
      bd_read(a, d);
      checks++;
      if (d !== ref_mem[a]) begin errors++; $display("FAIL %s addr %h got %h exp %h", name, a, d, ref_mem[a]); end
    end
  endtask

  task automatic check_rbuf(input logic [11:0] base, input int n, input string name);
    logic [11:0] a;
    for (int b = 0; b < n; b++) begin
      a = base + 12'(b);
      checks++;
      if (rbuf[b] !== ref_mem[a]) begin errors++; $display("FAIL %s byte %0d got %h exp %h", name, b, rbuf[b], ref_mem[a]); end
    end
  endtask

  task automatic check_oe(input string name);
    checks++;
    if (oe_viol !== 0) begin errors++; $display("FAIL %s oe violations got %0d exp 0", name, oe_viol); end
  endtask

  task automatic test_write_1bit();
    logic [23:0] ad;
    wbuf[0] = 8'hDE; wbuf[1] = 8'hAD; wbuf[2] = 8'hBE; wbuf[3] = 8'hEF;
    bus_write(8'h02, 24'h000010, 4);
    check_oe("write1_oe");
    check_ram(12'h010, 4, "write1_ram");
    // high address bits are don't-care
    ad = 24'($urandom);
    for (int b = 0; b < 3; b++) wbuf[b] = 8'($urandom);
    bus_write(8'h02, ad, 3);
    check_ram(ad[11:0], 3, "write1_rand_ram");
  endtask

  task automatic test_read_1bit();
    logic [23:0] ad;
    bd_write(12'h020, 8'h11); bd_write(12'h021, 8'h22);
    bd_write(12'h022, 8'h33); bd_write(12'h023, 8'h44);
    bus_read(8'h03, 24'h000020, 4);
    check_oe("read1_oe");
    check_rbuf(12'h020, 4, "read1_data");
    ad = 24'($urandom);
    bus_read(8'h03, ad, 3);
    check_oe("read1_rand_oe");
    check_rbuf(ad[11:0], 3, "read1_rand_data");
  endtask

  task automatic test_quad();
    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
    bus_write(8'h38, 24'h0007FE, 2);
    check_oe("quadw_oe");
    check_ram(12'h7FE, 2, "quadw_ram");
    bus_read(8'hEB, 24'h0007FE, 4);
    check_oe("quadr_oe_timing");
    check_rbuf(12'h7FE, 4, "quadr_data");
  endtask

  task automatic test_wrap();
    for (int b = 0; b < 4; b++) wbuf[b] = 8'($urandom);
    bus_write(8'h02, 24'h000FFE, 4);
    check_ram(12'hFFE, 4, "wrap_ram");
    bus_read(8'h03, 24'h005FFF, 3);
    check_rbuf(12'hFFF, 3, "wrap_read");
    bus_read(8'hEB, 24'hA00FFF, 2);
    check_rbuf(12'hFFF, 2, "wrap_qread");
  endtask

  task automatic test_abort();
    logic [11:0] a;
    a = 12'($urandom);
    oe_viol = 0;
    xfer_start();
    send_hdr(8'h02, {12'h000, a});
    repeat (5) sbit({3'b000, 1'($urandom)}, 4'b0000);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_mid got %b exp 1", busy); end
    #(HALF);
    cs_n = 1'b1;
    repeat (SS + 1) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_drop got %b exp 0", busy); end
    repeat (4) @(negedge clk);
    check_oe("abort_oe");
    check_ram(a, 1, "abort_ram");
    // unknown command: ignored until cs_n rises
    oe_viol = 0;
    xfer_start();
    send_hdr(8'h9F, 24'($urandom));
    repeat (16) sbit(4'($urandom), 4'b0000);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got %b exp 1", busy); end
    #(HALF);
    cs_n = 1'b1;
    repeat (SS + 1) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_drop got %b exp 0", busy); end
    repeat (4) @(negedge clk);
    check_oe("ignore_oe");
  endtask

  task automatic test_reset_mid();
    logic [23:0] ad;
    ad = 24'($urandom);
    oe_viol = 0;
    xfer_start();
    send_hdr(8'hEB, ad);
    repeat (DC) sbit(4'h0, 4'b0000);
    sbit(4'h0, 4'b1111);
    sbit(4'h0, 4'b1111);
    sclk = 1'b0;
    #(HALF);
    checks++; if (sio_oe !== 4'b1111) begin errors++; $display("FAIL rstmid_oe_before got %b exp 1111", sio_oe); end
    resetn = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (sio_oe !== 4'b0000) begin errors++; $display("FAIL rstmid_oe got %b exp 0000", sio_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    sclk = 1'b1;
    cs_n = 1'b1;
    repeat (5) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    ad = 24'($urandom);
    bus_read(8'h03, ad, 2);
    check_oe("rstmid_next_oe");
    check_rbuf(ad[11:0], 2, "rstmid_next_data");
  endtask

  task automatic test_back_to_back();
    logic [7:0] cmd;
    logic [23:0] ad;
    int n;
    for (int it = 0; it < 8; it++) begin
      case ($urandom_range(3, 0))
        0: cmd = 8'h02;
        1: cmd = 8'h03;
        2: cmd = 8'h38;
        default: cmd = 8'hEB;
      endcase
      ad = 24'($urandom);
      n = $urandom_range(4, 1);
      if (cmd == 8'h02 || cmd == 8'h38) begin
        for (int b = 0; b < n; b++) wbuf[b] = 8'($urandom);
        bus_write(cmd, ad, n);
        check_ram(ad[11:0], n, "b2b_ram");
      end else begin
        bus_read(cmd, ad, n);
        check_rbuf(ad[11:0], n, "b2b_read");
      end
      check_oe("b2b_oe");
    end
  endtask

  initial begin
    test_reset();
    test_backdoor();
    test_write_1bit();
    test_read_1bit();
    test_quad();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
